// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO responder.
package mdio_pkg;

  typedef enum logic [3:0] {
    IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA, ABORT
  } mdio_state_e;

  localparam logic [1:0] OP_RD    = 2'b10;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizer for an asynchronous clock-like input plus a 1-clk rising-edge strobe.
module mdio_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/mdio_responder.sv
// PHY-side Clause 22 MDIO responder with a 32x16 register file, sampled on oversampled MDC rises.
// Define MDIO_RSP_BCAST_EN to also accept writes addressed to PHYAD 0.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR  = 5'd1,
  parameter int          PRE_LEN   = 32,
  parameter logic [15:0] REG0_INIT = 16'h1140
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic [15:0] status_i,
  output logic        wr_stb,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy
);

  localparam int PW = $clog2(PRE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);

  logic rise;
  logic mdio_meta_q, mdio_meta_d;
  logic mdio_s_q, mdio_s_d;

  mdio_state_e   state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [15:0]   sh_in;
  logic          is_rd_q, is_rd_d;
  logic          match_q, match_d;
  logic [4:0]    regad_q, regad_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_oe_q, mdio_oe_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic [15:0]   regs_q [32];
  logic [15:0]   regs_d [32];

  mdio_sync_edge u_mdc_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mdc_i),
    .rise_o (rise)
  );

  always_comb begin
    mdio_meta_d = mdio_i;
    mdio_s_d    = mdio_meta_q;
  end

  assign sh_in = {shreg_q[14:0], mdio_s_q};

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    is_rd_d   = is_rd_q;
    match_d   = match_q;
    regad_d   = regad_q;
    mdio_o_d  = mdio_o_q;
    mdio_oe_d = mdio_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    regs_d    = regs_q;

    if (rise) begin
      unique case (state_q)
        IDLE: begin
          if (mdio_s_q) begin
            if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
          end else if (pre_cnt_q == PRE_MAX) begin
            state_d   = ST;
            busy_d    = 1'b1;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end
        ST: begin
          bit_cnt_d = 5'd1;
          state_d   = mdio_s_q ? OP : ABORT;
        end
        OP: begin
          shreg_d = sh_in;
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else if (sh_in[1:0] == OP_RD || sh_in[1:0] == OP_WR) begin
            is_rd_d   = (sh_in[1:0] == OP_RD);
            bit_cnt_d = 5'd4;
            state_d   = PHYAD;
          end else begin
            state_d = ABORT;
          end
        end
        PHYAD: begin
          shreg_d = sh_in;
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else begin
`ifdef MDIO_RSP_BCAST_EN
            match_d = (sh_in[4:0] == PHY_ADDR) || (!is_rd_q && sh_in[4:0] == 5'd0);
`else
            match_d = (sh_in[4:0] == PHY_ADDR);
`endif
            bit_cnt_d = 5'd4;
            state_d   = REGAD;
          end
        end
        REGAD: begin
          shreg_d = sh_in;
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else begin
            regad_d   = sh_in[4:0];
            bit_cnt_d = 5'd1;
            state_d   = TA;
          end
        end
        TA: begin
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = 5'd0;
            if (is_rd_q) begin
              // Read word is frozen here so the whole response is one coherent snapshot.
              shreg_d = (regad_q == REG_BMSR) ? status_i : regs_q[regad_q];
              if (match_q) begin
                mdio_oe_d = 1'b1;
                mdio_o_d  = 1'b0;
              end
            end else if (!mdio_s_q) begin
              state_d = ABORT;
            end
          end else begin
            bit_cnt_d = 5'd15;
            if (is_rd_q) begin
              if (match_q) mdio_o_d = shreg_q[15];
              shreg_d = {shreg_q[14:0], 1'b0};
              state_d = RDATA;
            end else begin
              state_d = mdio_s_q ? ABORT : WDATA;
            end
          end
        end
        RDATA: begin
          if (bit_cnt_q != 5'd0) begin
            if (match_q) mdio_o_d = shreg_q[15];
            shreg_d   = {shreg_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else begin
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end
        WDATA: begin
          shreg_d = sh_in;
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else begin
            if (match_q) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = regad_q;
              wr_data_d = sh_in;
              // BMSR is live status; BMCR bit 15 is a self-clearing reset request.
              if (regad_q == REG_BMCR)      regs_d[REG_BMCR] = {1'b0, sh_in[14:0]};
              else if (regad_q != REG_BMSR) regs_d[regad_q] = sh_in;
            end
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        ABORT: begin
          mdio_oe_d = 1'b0;
          mdio_o_d  = 1'b1;
          busy_d    = 1'b0;
          pre_cnt_d = '0;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mdio_meta_q <= 1'b1;
      mdio_s_q    <= 1'b1;
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      is_rd_q     <= 1'b0;
      match_q     <= 1'b0;
      regad_q     <= '0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= (i == 0) ? REG0_INIT : 16'h0000;
    end else begin
      mdio_meta_q <= mdio_meta_d;
      mdio_s_q    <= mdio_s_d;
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      is_rd_q     <= is_rd_d;
      match_q     <= match_d;
      regad_q     <= regad_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
      busy_q      <= busy_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  assign mdio_o  = mdio_o_q;
  assign mdio_oe = mdio_oe_q;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: a station-side bit driver with write/read scoreboards.
module tb_mdio_responder;
  import mdio_pkg::*;

`ifdef MDIO_RSP_BCAST_EN
  localparam logic BCAST = 1'b1;
`else
  localparam logic BCAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc_in;
  logic        mdio_in;
  logic        mdio_o;
  logic        mdio_oe;
  logic [15:0] status_in;
  logic        wr_stb;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [20:0] exp_wr[$];
  logic [15:0] exp_rd[$];

  mdio_responder dut (
    .clk      (clk),
    .rst      (rst),
    .mdc_i    (mdc_in),
    .mdio_i   (mdio_in),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe),
    .status_i (status_in),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every wr_stb must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst === 1'b0 && wr_stb === 1'b1) begin
      n_chk++;
      assert (exp_wr.size() != 0) else begin
        n_fail++;
        $error("FAIL wr_stb_unexpected: observed addr %0h data %0h expected no commit", wr_addr, wr_data);
      end
      if (exp_wr.size() != 0) begin
        logic [20:0] e;
        e = exp_wr.pop_front();
        check("wr_addr", {27'd0, wr_addr}, {27'd0, e[20:16]});
        check("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
      end
    end
  end

  // One MDC period per bit: data set in the low phase, sampled by the DUT on the rise.
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                       input int rst_at, output logic [15:0] rd, output logic oe_any,
                       output logic busy_any, output logic ta_ok);
    logic bits[$];
    logic so[$];
    logic soe[$];
    int   hdr;
    oe_any   = 1'b0;
    busy_any = 1'b0;
    rd       = '0;
    for (int i = 0; i < pre; i++) bits.push_back(1'b1);
    bits.push_back(1'b0);
    bits.push_back(1'b1);
    bits.push_back(op[1]);
    bits.push_back(op[0]);
    for (int i = 4; i >= 0; i--) bits.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) bits.push_back(ra[i]);
    bits.push_back(ta[1]);
    bits.push_back(ta[0]);
    for (int i = 15; i >= 0; i--) bits.push_back(wd[i]);
    hdr = pre + 14;
    for (int k = 0; k < bits.size(); k++) begin
      mdio_in = bits[k];
      if (k == rst_at) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
      repeat (8) @(negedge clk);
      so.push_back(mdio_o);
      soe.push_back(mdio_oe);
      oe_any   = oe_any | mdio_oe;
      busy_any = busy_any | busy;
      mdc_in = 1'b1;
      repeat (8) @(negedge clk);
      mdc_in = 1'b0;
    end
    mdio_in = 1'b1;
    ta_ok = !soe[hdr] && soe[hdr+1] && !so[hdr+1];
    for (int i = 0; i < 16; i++) begin
      ta_ok     = ta_ok & soe[hdr+2+i];
      rd[15-i]  = so[hdr+2+i];
    end
  endtask

  task automatic do_write(input string tag, input logic [4:0] phy, input logic [4:0] ra,
                          input logic [1:0] ta, input logic [15:0] wd, input int rst_at,
                          input logic commit);
    logic [15:0] rd;
    logic oe_any, busy_any, ta_ok;
    if (commit) exp_wr.push_back({ra, wd});
    frame(32, OP_WR, phy, ra, ta, wd, rst_at, rd, oe_any, busy_any, ta_ok);
    check({tag, "_pending"}, exp_wr.size(), 0);
    check({tag, "_oe_any"}, {31'd0, oe_any}, 0);
    check({tag, "_busy_end"}, {31'd0, busy}, 0);
  endtask

  task automatic do_read(input string tag, input int pre, input logic [4:0] phy,
                         input logic [4:0] ra, input logic answer, input logic [15:0] exp,
                         output logic busy_any);
    logic [15:0] rd;
    logic oe_any, ta_ok;
    if (answer) exp_rd.push_back(exp);
    frame(pre, OP_RD, phy, ra, 2'b11, 16'hFFFF, -1, rd, oe_any, busy_any, ta_ok);
    if (answer) begin
      check({tag, "_data"}, {16'd0, rd}, {16'd0, exp_rd.pop_front()});
      check({tag, "_ta_oe"}, {31'd0, ta_ok}, 1);
    end else begin
      check({tag, "_silent"}, {31'd0, oe_any}, 0);
    end
    check({tag, "_oe_release"}, {31'd0, mdio_oe}, 0);
    check({tag, "_o_idle"}, {31'd0, mdio_o}, 1);
    check({tag, "_busy_end"}, {31'd0, busy}, 0);
  endtask

  initial begin
    logic bsy;
    rst       = 1'b1;
    mdc_in    = 1'b0;
    mdio_in   = 1'b1;
    status_in = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_mdio_o", {31'd0, mdio_o}, 1);
    check("rst_mdio_oe", {31'd0, mdio_oe}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_wr_stb", {31'd0, wr_stb}, 0);
    check("rst_wr_addr_data", {11'd0, wr_addr, wr_data}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_write("wr_r4", 5'd1, 5'd4, 2'b10, 16'h01E1, -1, 1'b1);
    do_read("rd_r4", 32, 5'd1, 5'd4, 1'b1, 16'h01E1, bsy);

    status_in = 16'h796D;
    do_read("rd_bmsr", 32, 5'd1, REG_BMSR, 1'b1, 16'h796D, bsy);
    do_read("rd_r4_after_bmsr", 32, 5'd1, 5'd4, 1'b1, 16'h01E1, bsy);
    do_write("wr_bmsr", 5'd1, REG_BMSR, 2'b10, 16'hBEEF, -1, 1'b1);
    do_read("rd_bmsr_ro", 32, 5'd1, REG_BMSR, 1'b1, 16'h796D, bsy);

    do_read("rd_pre31", 31, 5'd1, 5'd4, 1'b0, 16'h0000, bsy);
    check("pre31_busy_any", {31'd0, bsy}, 0);

    do_read("rd_phy3", 32, 5'd3, 5'd4, 1'b0, 16'h0000, bsy);
    do_read("rd_phy1_after", 32, 5'd1, 5'd4, 1'b1, 16'h01E1, bsy);

    do_write("wr_bmcr", 5'd1, REG_BMCR, 2'b10, 16'h9140, -1, 1'b1);
    do_read("rd_bmcr", 32, 5'd1, REG_BMCR, 1'b1, 16'h1140, bsy);

    do_write("wr_bad_ta", 5'd1, 5'd5, 2'b11, 16'h1234, -1, 1'b0);
    do_read("rd_r5", 32, 5'd1, 5'd5, 1'b1, 16'h0000, bsy);

    do_write("wr_rst_mid", 5'd1, 5'd4, 2'b10, 16'hAAAA, 32 + 14 + 2 + 8, 1'b0);
    do_read("rd_r4_post_rst", 32, 5'd1, 5'd4, 1'b1, 16'h0000, bsy);
    do_read("rd_r0_post_rst", 32, 5'd1, REG_BMCR, 1'b1, 16'h1140, bsy);

    do_write("wr_bcast", 5'd0, 5'd4, 2'b10, 16'h0DE1, -1, BCAST);
    do_read("rd_phy0", 32, 5'd0, 5'd4, 1'b0, 16'h0000, bsy);
    do_read("rd_r4_bcast", 32, 5'd1, 5'd4, 1'b1, BCAST ? 16'h0DE1 : 16'h0000, bsy);

    repeat (4) @(negedge clk);
    check("final_wr_queue", exp_wr.size(), 0);
    check("final_rd_queue", exp_rd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
